l2_req_arbiter: RTL and testbench

Shares the single L2 request/response port between the L1 data cache and the L1 instruction cache, with one transaction outstanding at a time. It latches single-cycle miss pulses from each L1 and grants the port round-robin. Responses are steered back to the granted L1. It also sequences the whole-hierarchy flush: wait for both L1 flushes, then issue one L2 flush, with new grants held off. It sits between the `l1d`/`l1i` instances and the `l2` instance in the core top level.

---
 rtl/l2_req_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_l2_req_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares the single L2 request port between L1D and L1I.
// Holds one transaction outstanding at a time. Miss pulses are latched into
// pending bits and granted round-robin. Responses are steered back to the
// granted side. Also sequences the hierarchy flush: both L1 flushes, then one
// L2 flush, with new grants held off while the L2 flush is pending.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   l1d_req_* / l1d_rsp_valid     L1D miss pulse + fields, response strobe
//   l1i_req_* / l1i_rsp_valid     L1I miss pulse + fields, response strobe
//   l2_req_* / l2_req_ack         registered request to L2, accept strobe
//   l2_rsp_valid                  L2 response strobe
//   flush_req_l1d/l1i             flush-start pulses from the core
//   l1d/l1i/l2_flush_complete     flush-done pulses
//   l2_flush_req, flush_busy      L2 flush pulse, flush-in-progress flag
//   flush_done                    pulse when the L2 flush completes
//   gnt_l1d_count, gnt_l1i_count  wrapping grant counters
module l2_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l1d_req_valid,
  input  logic [ADDR_WIDTH-1:0] l1d_req_addr,
  input  logic [3:0]            l1d_req_opcode,
  input  logic [DATA_WIDTH-1:0] l1d_req_store_data,
  output logic                  l1d_rsp_valid,
  input  logic                  l1i_req_valid,
  input  logic [ADDR_WIDTH-1:0] l1i_req_addr,
  input  logic [3:0]            l1i_req_opcode,
  output logic                  l1i_rsp_valid,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ack,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  output logic [3:0]            l2_req_opcode,
  output logic [DATA_WIDTH-1:0] l2_req_store_data,
  input  logic                  l2_rsp_valid,
  input  logic                  flush_req_l1d,
  input  logic                  flush_req_l1i,
  input  logic                  l1d_flush_complete,
  input  logic                  l1i_flush_complete,
  output logic                  l2_flush_req,
  input  logic                  l2_flush_complete,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  gnt_l1d_count,
  output logic [CNT_WIDTH-1:0]  gnt_l1i_count
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_L1D, ARB_L1I} arb_state_e;
  typedef enum logic [1:0] {F_IDLE, F_WAIT_L1, F_L2_REQ, F_L2_WAIT} flush_state_e;

  arb_state_e              arb_q, arb_d;
  flush_state_e            fst_q, fst_d;
  logic                    pend_l1d_q, pend_l1d_d, pend_l1i_q, pend_l1i_d;
  logic                    pend_l1d_n, pend_l1i_n;
  logic                    last_gnt_q, last_gnt_d;   // 0: L1D granted last
  logic                    req_out_q, req_out_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]    gnt_l1d_cnt_q, gnt_l1d_cnt_d, gnt_l1i_cnt_q, gnt_l1i_cnt_d;
  logic                    done_l1d_q, done_l1d_d, done_l1i_q, done_l1i_d;
  logic                    l2_flush_req_q, l2_flush_req_d;
  logic                    gnt_l1d, gnt_l1i, flush_block;

  assign pend_l1d_n  = pend_l1d_q | l1d_req_valid;
  assign pend_l1i_n  = pend_l1i_q | l1i_req_valid;
  assign flush_block = (fst_q == F_L2_REQ) || (fst_q == F_L2_WAIT);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q          <= ARB_IDLE;
      fst_q          <= F_IDLE;
      pend_l1d_q     <= 1'b0;
      pend_l1i_q     <= 1'b0;
      last_gnt_q     <= 1'b0;
      req_out_q      <= 1'b0;
      addr_q         <= '0;
      opcode_q       <= '0;
      data_q         <= '0;
      gnt_l1d_cnt_q  <= '0;
      gnt_l1i_cnt_q  <= '0;
      done_l1d_q     <= 1'b0;
      done_l1i_q     <= 1'b0;
      l2_flush_req_q <= 1'b0;
    end else begin
      arb_q          <= arb_d;
      fst_q          <= fst_d;
      pend_l1d_q     <= pend_l1d_d;
      pend_l1i_q     <= pend_l1i_d;
      last_gnt_q     <= last_gnt_d;
      req_out_q      <= req_out_d;
      addr_q         <= addr_d;
      opcode_q       <= opcode_d;
      data_q         <= data_d;
      gnt_l1d_cnt_q  <= gnt_l1d_cnt_d;
      gnt_l1i_cnt_q  <= gnt_l1i_cnt_d;
      done_l1d_q     <= done_l1d_d;
      done_l1i_q     <= done_l1i_d;
      l2_flush_req_q <= l2_flush_req_d;
    end
  end

  // Arbiter: round-robin grant from idle, track ack/response while granted.
  always_comb begin
    arb_d         = arb_q;
    pend_l1d_d    = pend_l1d_n;
    pend_l1i_d    = pend_l1i_n;
    last_gnt_d    = last_gnt_q;
    req_out_d     = req_out_q;
    addr_d        = addr_q;
    opcode_d      = opcode_q;
    data_d        = data_q;
    gnt_l1d_cnt_d = gnt_l1d_cnt_q;
    gnt_l1i_cnt_d = gnt_l1i_cnt_q;
    gnt_l1d       = 1'b0;
    gnt_l1i       = 1'b0;
    case (arb_q)
      ARB_IDLE: begin
        if (!flush_block) begin
          if (pend_l1d_n && pend_l1i_n) begin
            gnt_l1i = ~last_gnt_q;
            gnt_l1d = last_gnt_q;
          end else begin
            gnt_l1d = pend_l1d_n;
            gnt_l1i = pend_l1i_n;
          end
        end
      end
      ARB_L1D, ARB_L1I: begin
        if (l2_req_ack) req_out_d = 1'b0;
        if (l2_rsp_valid) begin
          req_out_d = 1'b0;
          arb_d     = ARB_IDLE;
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
    if (gnt_l1d) begin
      arb_d         = ARB_L1D;
      pend_l1d_d    = 1'b0;
      last_gnt_d    = 1'b0;
      req_out_d     = 1'b1;
      addr_d        = l1d_req_addr;
      opcode_d      = l1d_req_opcode;
      data_d        = l1d_req_store_data;
      gnt_l1d_cnt_d = gnt_l1d_cnt_q + CNT_WIDTH'(1);
    end
    if (gnt_l1i) begin
      arb_d         = ARB_L1I;
      pend_l1i_d    = 1'b0;
      last_gnt_d    = 1'b1;
      req_out_d     = 1'b1;
      addr_d        = l1i_req_addr;
      opcode_d      = l1i_req_opcode;
      data_d        = '0;
      gnt_l1i_cnt_d = gnt_l1i_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Flush sequencer: L1 flushes, then a single L2 flush once the port is quiet.
  always_comb begin
    fst_d          = fst_q;
    done_l1d_d     = done_l1d_q;
    done_l1i_d     = done_l1i_q;
    l2_flush_req_d = 1'b0;
    case (fst_q)
      F_IDLE: begin
        if (flush_req_l1d || flush_req_l1i) begin
          fst_d      = F_WAIT_L1;
          // A side that was not asked to flush counts as already done.
          done_l1d_d = ~flush_req_l1d | l1d_flush_complete;
          done_l1i_d = ~flush_req_l1i | l1i_flush_complete;
        end
      end
      F_WAIT_L1: begin
        if (l1d_flush_complete) done_l1d_d = 1'b1;
        if (l1i_flush_complete) done_l1i_d = 1'b1;
        if (done_l1d_q && done_l1i_q) fst_d = F_L2_REQ;
      end
      F_L2_REQ: begin
        if (arb_q == ARB_IDLE && !req_out_q) begin
          l2_flush_req_d = 1'b1;
          fst_d          = F_L2_WAIT;
        end
      end
      F_L2_WAIT: begin
        if (l2_flush_complete) begin
          fst_d      = F_IDLE;
          done_l1d_d = 1'b0;
          done_l1i_d = 1'b0;
        end
      end
      default: fst_d = F_IDLE;
    endcase
  end

  assign l2_req_valid      = req_out_q;
  assign l2_req_addr       = addr_q;
  assign l2_req_opcode     = opcode_q;
  assign l2_req_store_data = data_q;
  assign gnt_l1d_count     = gnt_l1d_cnt_q;
  assign gnt_l1i_count     = gnt_l1i_cnt_q;
  assign l2_flush_req      = l2_flush_req_q;
  assign flush_busy        = (fst_q != F_IDLE);
  // Response and flush-done strobes follow their trigger inputs in-cycle.
  assign l1d_rsp_valid     = (arb_q == ARB_L1D) && l2_rsp_valid;
  assign l1i_rsp_valid     = (arb_q == ARB_L1I) && l2_rsp_valid;
  assign flush_done        = (fst_q == F_L2_WAIT) && l2_flush_complete;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: stimulus pushes expected events and
// timed signal checks; the negedge monitor pops and compares them.
module tb_l2_req_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         l1d_req_valid = 1'b0, l1i_req_valid = 1'b0;
  logic [31:0]  l1d_req_addr = '0, l1i_req_addr = '0;
  logic [3:0]   l1d_req_opcode = '0, l1i_req_opcode = '0;
  logic [127:0] l1d_req_store_data = '0;
  logic         l1d_rsp_valid, l1i_rsp_valid;
  logic         l2_req_valid;
  logic         l2_req_ack = 1'b0, l2_rsp_valid = 1'b0;
  logic [31:0]  l2_req_addr;
  logic [3:0]   l2_req_opcode;
  logic [127:0] l2_req_store_data;
  logic         flush_req_l1d = 1'b0, flush_req_l1i = 1'b0;
  logic         l1d_flush_complete = 1'b0, l1i_flush_complete = 1'b0;
  logic         l2_flush_req, l2_flush_complete = 1'b0;
  logic         flush_busy, flush_done;
  logic [31:0]  gnt_l1d_count, gnt_l1i_count;

  l2_req_arbiter dut (
    .clk(clk), .reset(reset),
    .l1d_req_valid(l1d_req_valid), .l1d_req_addr(l1d_req_addr),
    .l1d_req_opcode(l1d_req_opcode), .l1d_req_store_data(l1d_req_store_data),
    .l1d_rsp_valid(l1d_rsp_valid),
    .l1i_req_valid(l1i_req_valid), .l1i_req_addr(l1i_req_addr),
    .l1i_req_opcode(l1i_req_opcode), .l1i_rsp_valid(l1i_rsp_valid),
    .l2_req_valid(l2_req_valid), .l2_req_ack(l2_req_ack),
    .l2_req_addr(l2_req_addr), .l2_req_opcode(l2_req_opcode),
    .l2_req_store_data(l2_req_store_data), .l2_rsp_valid(l2_rsp_valid),
    .flush_req_l1d(flush_req_l1d), .flush_req_l1i(flush_req_l1i),
    .l1d_flush_complete(l1d_flush_complete), .l1i_flush_complete(l1i_flush_complete),
    .l2_flush_req(l2_flush_req), .l2_flush_complete(l2_flush_complete),
    .flush_busy(flush_busy), .flush_done(flush_done),
    .gnt_l1d_count(gnt_l1d_count), .gnt_l1i_count(gnt_l1i_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int EV_GNT = 0, EV_RSP_D = 1, EV_RSP_I = 2, EV_FREQ = 3, EV_FDONE = 4;
  localparam int S_VLD = 0, S_ADDR = 1, S_OP = 2, S_DATA = 3, S_CNT_D = 4, S_CNT_I = 5,
                 S_BUSY = 6, S_FREQ = 7, S_RSP_D = 8, S_RSP_I = 9, S_FDONE = 10;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [3:0]   op;
    logic [127:0] data;
    int           cyc;     // -1: any cycle
  } ev_t;

  typedef struct {
    string        name;
    int           cyc;
    int           sig;
    logic [127:0] exp;
  } chk_t;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  function automatic void push_ev(input int k, input logic [31:0] a, input logic [3:0] o,
                                  input logic [127:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.op = o; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_at(input string name, input int dc, input int s,
                                    input logic [127:0] v);
    chk_t c;
    c.name = name; c.cyc = cyc + dc; c.sig = s; c.exp = v;
    chk_q.push_back(c);
  endfunction

  function automatic logic [127:0] sample(input int s);
    case (s)
      S_VLD:   return 128'(l2_req_valid);
      S_ADDR:  return 128'(l2_req_addr);
      S_OP:    return 128'(l2_req_opcode);
      S_DATA:  return l2_req_store_data;
      S_CNT_D: return 128'(gnt_l1d_count);
      S_CNT_I: return 128'(gnt_l1i_count);
      S_BUSY:  return 128'(flush_busy);
      S_FREQ:  return 128'(l2_flush_req);
      S_RSP_D: return 128'(l1d_rsp_valid);
      S_RSP_I: return 128'(l1i_rsp_valid);
      default: return 128'(flush_done);
    endcase
  endfunction

  task automatic check_ev(input int k);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d, required no event", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || (e.cyc >= 0 && e.cyc != cyc) ||
        (k == EV_GNT && (l2_req_addr !== e.addr || l2_req_opcode !== e.op ||
                         l2_req_store_data !== e.data))) begin
      n_fail++;
      $display("FAIL event got kind=%0d cyc=%0d addr=%h op=%h data=%h required kind=%0d cyc=%0d addr=%h op=%h data=%h",
               k, cyc, l2_req_addr, l2_req_opcode, l2_req_store_data,
               e.kind, e.cyc, e.addr, e.op, e.data);
    end
  endtask

  task automatic run_chk(input chk_t c);
    logic [127:0] act;
    act = sample(c.sig);
    n_tests++;
    if (act !== c.exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", c.name, cyc, act, c.exp);
    end
  endtask

  // Monitor: the only place comparisons are made and counted.
  bit prev_vld = 1'b0;
  always @(negedge clk) begin : mon
    int i;
    if (l1d_rsp_valid) check_ev(EV_RSP_D);
    if (l1i_rsp_valid) check_ev(EV_RSP_I);
    if (flush_done) check_ev(EV_FDONE);
    if (l2_req_valid && !prev_vld) check_ev(EV_GNT);
    if (l2_flush_req) check_ev(EV_FREQ);
    prev_vld = l2_req_valid;
    i = 0;
    while (i < chk_q.size()) begin
      if (chk_q[i].cyc == cyc) begin
        run_chk(chk_q[i]);
        chk_q.delete(i);
      end else begin
        i++;
      end
    end
    if (stim_done || cyc > 20000) begin
      n_tests++;
      if (cyc > 20000 || exp_q.size() != 0 || chk_q.size() != 0) begin
        n_fail++;
        $display("FAIL end_of_run pending_events=%0d pending_checks=%0d cyc=%0d, required 0 0 and cyc<=20000",
                 exp_q.size(), chk_q.size(), cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    l1d_req_valid = 0; l1i_req_valid = 0; flush_req_l1d = 0; flush_req_l1i = 0;
    l1d_flush_complete = 0; l1i_flush_complete = 0; l2_flush_complete = 0;
    l2_req_ack = 0; l2_rsp_valid = 0;
  endtask

  task automatic do_reset();
    clr_pulses();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // L2 model: ack one cycle after the request is seen, respond rsp_dly cycles after the ack.
  task automatic serve(input int rsp_dly);
    int n = 0;
    while (!l2_req_valid && n < 64) begin step(); n++; end
    if (!l2_req_valid) begin
      $display("[TB] serve: no request within 64 cycles at cyc %0d", cyc);
      return;
    end
    step(); l2_req_ack = 1'b1; l2_rsp_valid = (rsp_dly == 0);
    step(); l2_req_ack = 1'b0; l2_rsp_valid = 1'b0;
    if (rsp_dly > 0) begin
      repeat (rsp_dly - 1) step();
      l2_rsp_valid = 1'b1; step(); l2_rsp_valid = 1'b0;
    end
  endtask

  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] D2 = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;

  initial begin : stim
    int a;
    do_reset();
    expect_at("rst_vld", 0, S_VLD, 0);   expect_at("rst_addr", 0, S_ADDR, 0);
    expect_at("rst_op", 0, S_OP, 0);     expect_at("rst_data", 0, S_DATA, 0);
    expect_at("rst_cnt_d", 0, S_CNT_D, 0); expect_at("rst_cnt_i", 0, S_CNT_I, 0);
    expect_at("rst_busy", 0, S_BUSY, 0); expect_at("rst_freq", 0, S_FREQ, 0);

    // Single L1D miss with hand-placed ack and response.
    step(); a = cyc;
    l1d_req_addr = 32'h1000; l1d_req_opcode = 4'h2; l1d_req_store_data = D1; l1d_req_valid = 1;
    push_ev(EV_GNT, 32'h1000, 4'h2, D1, a + 1);
    push_ev(EV_RSP_D, '0, '0, '0, a + 7);
    expect_at("t1_cnt_d", 1, S_CNT_D, 1);
    expect_at("t1_vld_at_ack", 3, S_VLD, 1);
    expect_at("t1_vld_after_ack", 4, S_VLD, 0);
    expect_at("t1_rsp_i_quiet", 7, S_RSP_I, 0);
    expect_at("t1_cnt_i", 8, S_CNT_I, 0);
    for (int c = 1; c <= 8; c++) begin
      step(); clr_pulses();
      case (c)
        3: l2_req_ack = 1;
        7: l2_rsp_valid = 1;
        default: ;
      endcase
    end

    // Simultaneous pulses after reset: L1I first, then L1D right after the response.
    do_reset(); step(); a = cyc;
    l1d_req_addr = 32'h2000; l1d_req_opcode = 4'h3; l1d_req_store_data = D2;
    l1i_req_addr = 32'h3000; l1i_req_opcode = 4'h5;
    l1d_req_valid = 1; l1i_req_valid = 1;
    push_ev(EV_GNT, 32'h3000, 4'h5, '0, a + 1);
    push_ev(EV_RSP_I, '0, '0, '0, -1);
    push_ev(EV_GNT, 32'h2000, 4'h3, D2, -1);
    push_ev(EV_RSP_D, '0, '0, '0, -1);
    step(); clr_pulses();
    serve(2);
    expect_at("t2_gap", 0, S_VLD, 0);
    expect_at("t2_next_grant", 1, S_VLD, 1);
    serve(2);
    expect_at("t2_cnt_d", 0, S_CNT_D, 1);
    expect_at("t2_cnt_i", 0, S_CNT_I, 1);

    // Back-to-back contention, four misses per side, strictly alternating.
    do_reset(); step();
    for (int k = 0; k < 8; k++) begin
      int j;
      j = k / 2;
      if (k % 2 == 0) begin
        push_ev(EV_GNT, 32'h4000 + 32'(j * 64), 4'h1, '0, -1);
        push_ev(EV_RSP_I, '0, '0, '0, -1);
      end else begin
        push_ev(EV_GNT, 32'h5000 + 32'(j * 64), 4'h9, {4{32'(j + 1)}}, -1);
        push_ev(EV_RSP_D, '0, '0, '0, -1);
      end
    end
    l1i_req_addr = 32'h4000; l1i_req_opcode = 4'h1;
    l1d_req_addr = 32'h5000; l1d_req_opcode = 4'h9; l1d_req_store_data = {4{32'(1)}};
    l1d_req_valid = 1; l1i_req_valid = 1;
    step(); clr_pulses();
    for (int k = 0; k < 8; k++) begin
      int j;
      j = k / 2;
      serve(1);
      if (j < 3) begin
        if (k % 2 == 0) begin
          l1i_req_addr = 32'h4000 + 32'((j + 1) * 64); l1i_req_valid = 1;
        end else begin
          l1d_req_addr = 32'h5000 + 32'((j + 1) * 64);
          l1d_req_store_data = {4{32'(j + 2)}}; l1d_req_valid = 1;
        end
        step(); clr_pulses();
      end
    end
    expect_at("t3_cnt_d", 0, S_CNT_D, 4);
    expect_at("t3_cnt_i", 0, S_CNT_I, 4);
    expect_at("t3_idle", 1, S_VLD, 0);
    step(); step();

    // L1D pulse while L1I is granted is latched and served after the L1I response.
    do_reset(); step(); a = cyc;
    l1i_req_addr = 32'h6000; l1i_req_opcode = 4'h6; l1i_req_valid = 1;
    push_ev(EV_GNT, 32'h6000, 4'h6, '0, a + 1);
    push_ev(EV_RSP_I, '0, '0, '0, a + 7);
    push_ev(EV_GNT, 32'h7000, 4'h7, D1, a + 9);
    push_ev(EV_RSP_D, '0, '0, '0, -1);
    expect_at("t4_gap", 8, S_VLD, 0);
    expect_at("t4_cnt_d", 9, S_CNT_D, 1);
    for (int c = 1; c <= 9; c++) begin
      step(); clr_pulses();
      case (c)
        2: begin
          l1d_req_addr = 32'h7000; l1d_req_opcode = 4'h7;
          l1d_req_store_data = D1; l1d_req_valid = 1;
        end
        4: l2_req_ack = 1;
        7: l2_rsp_valid = 1;
        default: ;
      endcase
    end
    serve(0);

    // Full flush with an L1D miss in flight and an L1I miss arriving during the L2 flush.
    do_reset(); step(); a = cyc;
    l1d_req_addr = 32'h8000; l1d_req_opcode = 4'h8; l1d_req_store_data = D2; l1d_req_valid = 1;
    push_ev(EV_GNT, 32'h8000, 4'h8, D2, a + 1);
    push_ev(EV_RSP_D, '0, '0, '0, a + 9);
    push_ev(EV_FREQ, '0, '0, '0, a + 11);
    push_ev(EV_FDONE, '0, '0, '0, a + 14);
    push_ev(EV_GNT, 32'h9000, 4'h4, '0, a + 16);
    push_ev(EV_RSP_I, '0, '0, '0, -1);
    expect_at("t5_busy_start", 2, S_BUSY, 1);
    expect_at("t5_no_freq_early", 10, S_FREQ, 0);
    expect_at("t5_held_off", 13, S_VLD, 0);
    expect_at("t5_busy_at_done", 14, S_BUSY, 1);
    expect_at("t5_busy_clear", 15, S_BUSY, 0);
    expect_at("t5_held_until_done", 15, S_VLD, 0);
    for (int c = 1; c <= 16; c++) begin
      step(); clr_pulses();
      case (c)
        1: begin flush_req_l1d = 1; flush_req_l1i = 1; end
        3: l1i_flush_complete = 1;
        5: l1d_flush_complete = 1;
        6: l2_req_ack = 1;
        9: l2_rsp_valid = 1;
        12: begin l1i_req_addr = 32'h9000; l1i_req_opcode = 4'h4; l1i_req_valid = 1; end
        14: l2_flush_complete = 1;
        default: ;
      endcase
    end
    serve(0);

    // Reset in the middle of an L1D transaction, then a normal miss.
    do_reset(); step(); a = cyc;
    l1d_req_addr = 32'hA000; l1d_req_opcode = 4'hA; l1d_req_store_data = D1; l1d_req_valid = 1;
    push_ev(EV_GNT, 32'hA000, 4'hA, D1, a + 1);
    push_ev(EV_GNT, 32'hB000, 4'hB, D2, a + 5);
    push_ev(EV_RSP_D, '0, '0, '0, -1);
    expect_at("t6_vld_before_rst", 2, S_VLD, 1);
    expect_at("t6_rst_vld", 3, S_VLD, 0);
    expect_at("t6_rst_addr", 3, S_ADDR, 0);
    expect_at("t6_rst_data", 3, S_DATA, 0);
    expect_at("t6_rst_cnt_d", 3, S_CNT_D, 0);
    for (int c = 1; c <= 5; c++) begin
      step(); clr_pulses();
      case (c)
        2: reset = 1;
        3: reset = 0;
        4: begin
          l1d_req_addr = 32'hB000; l1d_req_opcode = 4'hB;
          l1d_req_store_data = D2; l1d_req_valid = 1;
        end
        default: ;
      endcase
    end
    serve(0);
    expect_at("t6_cnt_d", 0, S_CNT_D, 1);

    // L1I-only flush with same-cycle complete; a stray L2 response while idle is ignored.
    step(); a = cyc;
    flush_req_l1i = 1; l1i_flush_complete = 1;
    push_ev(EV_FREQ, '0, '0, '0, a + 3);
    push_ev(EV_FDONE, '0, '0, '0, a + 5);
    expect_at("t7_busy", 1, S_BUSY, 1);
    expect_at("t7_no_freq_early", 2, S_FREQ, 0);
    expect_at("t7_busy_clear", 6, S_BUSY, 0);
    expect_at("t7_rsp_d_idle", 6, S_RSP_D, 0);
    expect_at("t7_rsp_i_idle", 6, S_RSP_I, 0);
    for (int c = 1; c <= 8; c++) begin
      step(); clr_pulses();
      case (c)
        5: l2_flush_complete = 1;
        6: l2_rsp_valid = 1;
        default: ;
      endcase
    end
    step();
    stim_done = 1'b1;
  end

endmodule
